// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with its own sequencing FSM.
// Accepts one request in FREE, runs DATA_WIDTH steps (or a one-cycle divide-by-zero path), then holds the result.
module div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_i,
  input  logic                  rem_i,
  input  logic [DATA_WIDTH-1:0] opdata1_i,
  input  logic [DATA_WIDTH-1:0] opdata2_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rem_sel_q, rem_sel_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_WIDTH:0]   rem_sh, diff;
  logic                  no_borrow;
  logic [DATA_WIDTH-1:0] rem_step, quo_step, quo_fix, rem_fix;
  logic                  neg1, neg2;

  // Partial remainder is kept one bit wider so divisors above 2^(W-1) compare correctly.
  always_comb begin
    rem_sh    = {rem_q, quo_q[DATA_WIDTH-1]};
    diff      = rem_sh - {1'b0, dvs_q};
    no_borrow = ~diff[DATA_WIDTH];
    rem_step  = no_borrow ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
    quo_step  = {quo_q[DATA_WIDTH-2:0], no_borrow};
    quo_fix   = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
    rem_fix   = neg_rem_q ? (~rem_step + 1'b1) : rem_step;
    neg1      = signed_i & opdata1_i[DATA_WIDTH-1];
    neg2      = signed_i & opdata2_i[DATA_WIDTH-1];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_sel_d = rem_sel_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    ready_d   = ready_q;
    unique case (state_q)
      FREE: begin
        ready_d = 1'b0;
        if (start_i && !annul_i) begin
          rem_sel_d = rem_i;
          cnt_d     = '0;
          rem_d     = '0;
          if (opdata2_i == '0) begin
            // Raw dividend parked in quo_q doubles as the divide-by-zero remainder.
            quo_d     = opdata1_i;
            dvs_d     = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = BYZERO;
          end else begin
            quo_d     = neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
            dvs_d     = neg2 ? (~opdata2_i + 1'b1) : opdata2_i;
            neg_quo_d = neg1 ^ neg2;
            neg_rem_d = neg1;
            state_d   = ON;
          end
        end
      end
      BYZERO: begin
        if (annul_i) begin
          ready_d = 1'b0;
          state_d = FREE;
        end else begin
          result_d = rem_sel_q ? quo_q : '1;
          ready_d  = 1'b1;
          state_d  = END;
        end
      end
      ON: begin
        if (annul_i) begin
          ready_d = 1'b0;
          state_d = FREE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            result_d = rem_sel_q ? rem_fix : quo_fix;
            ready_d  = 1'b1;
            state_d  = END;
          end
        end
      end
      END: begin
        if (annul_i || !start_i) begin
          ready_d = 1'b0;
          state_d = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_sel_q <= rem_sel_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == BYZERO) || (state_q == ON);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized operations against an arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_i = 1'b0;
  logic        rem_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .rem_i     (rem_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain-arithmetic reference: truncating signed division, remainder follows the dividend.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn, input logic rm);
    longint sa, sb, q, r;
    if (b == 0) return rm ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return rm ? r[31:0] : q[31:0];
    end
    return rm ? (a % b) : (a / b);
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic rm, input logic [31:0] exp, input string tag);
    int lat, bsy, exp_lat;
    exp_lat   = (b == 0) ? 1 : 32;
    start_i   = 1'b1;
    opdata1_i = a;
    opdata2_i = b;
    signed_i  = sgn;
    rem_i     = rm;
    tick();
    // Operand changes after the accept edge must not matter.
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    signed_i  = ~sgn;
    rem_i     = ~rm;
    lat = 0;
    bsy = 0;
    while (!ready_o && lat < 100) begin
      if (busy_o) bsy++;
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, bsy, exp_lat);
    check({tag, "_res"}, result_o, exp);
    repeat (2) begin
      tick();
      check({tag, "_hold_rdy"}, 32'(ready_o), 32'd1);
      check({tag, "_hold_res"}, result_o, exp);
    end
    start_i = 1'b0;
    tick();
    check({tag, "_drop_rdy"}, 32'(ready_o), 32'd0);
    check({tag, "_drop_res"}, result_o, exp);
    check({tag, "_drop_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s, r;
    int          rdy_seen;

    #2;
    check("rst_res", result_o, 32'd0);
    check("rst_rdy", 32'(ready_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    run_op(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, "u100_7_q");
    run_op(32'd100, 32'd7, 1'b0, 1'b1, 32'd2, "u100_7_r");
    run_op(-32'sd7, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, "sm7_2_q");
    run_op(-32'sd7, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, "sm7_2_r");
    run_op(32'd7, -32'sd2, 1'b1, 1'b0, 32'hFFFF_FFFD, "s7_m2_q");
    run_op(32'd7, -32'sd2, 1'b1, 1'b1, 32'd1, "s7_m2_r");
    run_op(32'h1234_5678, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, "dz_s_q");
    run_op(32'h1234_5678, 32'd0, 1'b1, 1'b1, 32'h1234_5678, "dz_s_r");
    run_op(32'h1234_5678, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, "dz_u_q");
    run_op(32'h1234_5678, 32'd0, 1'b0, 1'b1, 32'h1234_5678, "dz_u_r");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, "ovf_s_q");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, "ovf_s_r");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, "ovf_u_q");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, "ovf_u_r");

    // Annul on the tenth edge after accept; the previous result must survive.
    start_i   = 1'b1;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    signed_i  = 1'b0;
    rem_i     = 1'b0;
    tick();
    rdy_seen = 0;
    repeat (9) begin
      tick();
      if (ready_o) rdy_seen++;
    end
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    check("annul_busy", 32'(busy_o), 32'd0);
    check("annul_rdy", 32'(ready_o), 32'd0);
    check("annul_res", result_o, 32'h8000_0000);
    check("annul_no_rdy", rdy_seen, 0);
    run_op(32'd50, 32'd5, 1'b0, 1'b0, 32'd10, "post_annul");

    // Asynchronous reset between clock edges while an operation runs.
    start_i   = 1'b1;
    opdata1_i = 32'd12345;
    opdata2_i = 32'd17;
    signed_i  = 1'b0;
    rem_i     = 1'b0;
    tick();
    repeat (5) tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_rdy", 32'(ready_o), 32'd0);
    check("arst_res", result_o, 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("arst_idle_busy", 32'(busy_o), 32'd0);
    run_op(32'd12345, 32'd17, 1'b0, 1'b0, 32'd726, "post_rst");

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 20);
        3:       b = -($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      run_op(a, b, s, r, ref_div(a, b, s, r), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-cycle radix-2 divider and its sequencing FSM, shared by DIV/DIVU/REM/REMU in the EX stage.
- EX raises start_i with captured operands and holds stallreq asserted until ready_o is seen.
- The unit owns all multi-cycle sequencing: operand capture, sign fix-up, divide-by-zero shortcut, annul on pipeline flush, and result hold until EX releases start_i.

Parameters:
- DATA_WIDTH, 32, operand and result width. The iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  request; sampled only in FREE.
- annul_i  in  1  flush; cancels any operation in progress.
- signed_i  in  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU.
- rem_i  in  1  1 = return remainder, 0 = return quotient.
- opdata1_i  in  DATA_WIDTH  dividend.
- opdata2_i  in  DATA_WIDTH  divisor.
- result_o  out  DATA_WIDTH  quotient or remainder; registered.
- ready_o  out  1  result valid; registered.
- busy_o  out  1  high in BYZERO or ON.

Behaviour:
- Reset (rst=0, asynchronous): state=FREE, counter=0, result_o=0, ready_o=0, all internal operand/partial registers=0. Reset mid-operation discards the operation with no result.
- States:
  - FREE: ready_o=0. If start_i=1 and annul_i=0:
    - latch signed_i, rem_i and the operands;
    - if opdata2_i==0, go to BYZERO;
    - else store |dividend| and |divisor| (magnitudes only when signed_i=1), plus sign flags, and go to ON with counter=0.
    - Otherwise stay in FREE.
  - BYZERO: go to END on the next edge. Quotient=all ones; remainder=dividend unmodified.
  - ON: one restoring step per edge.
    - Shift the {rem,quo} pair left 1 and trial-subtract the divisor from the upper half.
    - If no borrow, keep the difference and set quo LSB=1; otherwise restore and set LSB=0.
    - counter increments each step. When counter reaches DATA_WIDTH-1, that step completes and the state goes to END.
  - END: ready_o=1 and result_o valid and stable.
    - Stay in END while start_i=1; go to FREE on the first edge with start_i=0 (ready_o=0 from then on).
- Sign fix-up, applied when entering END from ON with signed_i=1:
  - quotient negated if the operand signs differ;
  - remainder takes the sign of the dividend (negated if the dividend is negative).
- Overflow: signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0 through the normal datapath, with no special case.
- Latency:
  - Accept edge E0.
  - Normal divide: ready_o high after edge E32 (DATA_WIDTH+1 edges from accept to END).
  - Divide-by-zero: ready_o high after E1.
- Annul:
  - annul_i=1 in BYZERO, ON or END forces FREE on the next edge, with ready_o=0 and result_o unchanged.
  - annul_i has priority over start_i in every state.
  - An annulled operation never asserts ready_o.
- Input changes: opdata*/signed_i/rem_i changes after the accept edge are ignored. start_i dropping during ON or BYZERO does not stop the operation; the FSM reaches END, then returns to FREE on the next edge because start_i=0.
- Back-to-back: a new start_i is only accepted in FREE. A held start_i after END→FREE is accepted as a new operation on the following edge.
- busy_o is decoded from the state register; no combinational path from inputs.

Test Plan:
- Unsigned 100/7, rem_i=0:
  - result_o=14 with ready_o rising after edge 32 post-accept;
  - repeat with rem_i=1 → result_o=2;
  - ready_o held while start_i=1 and dropped one edge after start_i=0.
- Signed -7/2:
  - rem_i=0 → 0xFFFFFFFD;
  - rem_i=1 → 0xFFFFFFFF;
  - 7/-2 → quotient 0xFFFFFFFD, remainder 1.
- Divide-by-zero, dividend 0x12345678, signed and unsigned:
  - rem_i=0 → 0xFFFFFFFF;
  - rem_i=1 → 0x12345678;
  - ready_o after edge 1, busy_o high for exactly 1 cycle.
- Signed 0x80000000 / 0xFFFFFFFF:
  - quotient 0x80000000, remainder 0;
  - unsigned same operands → quotient 0, remainder 0x80000000.
- Annul at edge 10 of ON:
  - state returns to FREE, ready_o never asserts;
  - a new start (50/5) issued the next cycle returns 10 after a full 32-step latency.
- Drive rst=0 asynchronously (mid-clock) during ON:
  - ready_o and result_o go to 0 immediately;
  - after release, an operation completes with correct latency.
